mem_intf_arbiter: RTL and testbench

- Two-requester arbiter that shares one MemIntf-style memory port, e.g. between Blimp instruction fetch and a data unit, in front of a single memory server.
- Round-robin request grant with grant locking while a request is stalled.
- Tags each request with the requester ID in an extra opaque MSB and routes responses back by that tag.
- Bounds in-flight transactions with an outstanding counter.

---
 rtl/mem_intf_arbiter_pkg.sv | 20 ++
 rtl/mem_intf_arbiter_rr_grant.sv | 53 +++++
 rtl/mem_intf_arbiter.sv | 108 ++++++++++
 tb/tb_mem_intf_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_intf_arbiter_pkg.sv
// rtl/mem_intf_arbiter_pkg.sv - message layouts and helpers shared by the memory port arbiter
`ifndef MEM_INTF_ARBITER_PKG_SV
`define MEM_INTF_ARBITER_PKG_SV

`define MEM_REQ_T(OB) struct packed { logic op; logic [(OB)-1:0] opaq; logic [31:0] addr; logic [31:0] data; }
`define MEM_RESP_T(OB) struct packed { logic op; logic [(OB)-1:0] opaq; logic [31:0] data; }

package mem_intf_arbiter_pkg;

  localparam logic MEM_OP_READ  = 1'b0;
  localparam logic MEM_OP_WRITE = 1'b1;

  // The requester ID sits just above the requester's own opaque field.
  function automatic int id_bit_pos(input int opaq_bits);
    return opaq_bits;
  endfunction

endpackage

`endif

// File: rtl/mem_intf_arbiter_rr_grant.sv
// rtl/mem_intf_arbiter_rr_grant.sv - round-robin grant with locking while the memory port stalls
module mem_intf_arbiter_rr_grant (
  input  logic clk,
  input  logic rst,
  input  logic req0_val,
  input  logic req1_val,
  input  logic mem_req_val,
  input  logic mem_req_rdy,
  output logic grant,
  output logic lock
);

  logic prio_q, prio_d;
  logic lock_q, lock_d;
  logic lock_id_q, lock_id_d;

  always_comb begin
    if (lock_q)                    grant = lock_id_q;
    else if (req0_val && req1_val) grant = prio_q;
    else if (req0_val)             grant = 1'b0;
    else if (req1_val)             grant = 1'b1;
    else                           grant = prio_q;
  end

  // A stalled request pins the grant so val/msg stay stable until it is taken.
  always_comb begin
    prio_d    = prio_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (mem_req_val && mem_req_rdy) begin
      prio_d = ~grant;
      lock_d = 1'b0;
    end else if (mem_req_val) begin
      lock_d    = 1'b1;
      lock_id_d = grant;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q    <= 1'b0;
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
    end else begin
      prio_q    <= prio_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end

  assign lock = lock_q;

endmodule

// File: rtl/mem_intf_arbiter.sv
// rtl/mem_intf_arbiter.sv - two-requester arbiter sharing one memory port with tag-routed responses
module mem_intf_arbiter
  import mem_intf_arbiter_pkg::*;
#(
  parameter int p_opaq_bits       = 8,
  parameter int p_max_outstanding = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_val,
  output logic                   req0_rdy,
  input  logic [p_opaq_bits+64:0] req0_msg,
  input  logic                   req1_val,
  output logic                   req1_rdy,
  input  logic [p_opaq_bits+64:0] req1_msg,
  output logic                   resp0_val,
  input  logic                   resp0_rdy,
  output logic [p_opaq_bits+32:0] resp0_msg,
  output logic                   resp1_val,
  input  logic                   resp1_rdy,
  output logic [p_opaq_bits+32:0] resp1_msg,
  output logic                   mem_req_val,
  input  logic                   mem_req_rdy,
  output logic [p_opaq_bits+65:0] mem_req_msg,
  input  logic                   mem_resp_val,
  output logic                   mem_resp_rdy,
  input  logic [p_opaq_bits+33:0] mem_resp_msg
);

  localparam int CW     = $clog2(p_max_outstanding + 1);
  localparam int ID_BIT = id_bit_pos(p_opaq_bits);

  typedef `MEM_REQ_T(p_opaq_bits)    req_t;
  typedef `MEM_REQ_T(p_opaq_bits+1)  mreq_t;
  typedef `MEM_RESP_T(p_opaq_bits)   resp_t;
  typedef `MEM_RESP_T(p_opaq_bits+1) mresp_t;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          grant, lock, full, resp_id, req_fire, resp_fire;
  req_t          sel_req;
  mreq_t         fwd_req;
  mresp_t        mem_resp;
  resp_t         ret_resp;

  mem_intf_arbiter_rr_grant u_grant (
    .clk         (clk),
    .rst         (rst),
    .req0_val    (req0_val),
    .req1_val    (req1_val),
    .mem_req_val (mem_req_val),
    .mem_req_rdy (mem_req_rdy),
    .grant       (grant),
    .lock        (lock)
  );

  // Handshake outputs are gated by rst so they drop the moment reset asserts.
  always_comb begin
    full         = (cnt_q == CW'(p_max_outstanding));
    sel_req      = grant ? req1_msg : req0_msg;
    fwd_req.op   = sel_req.op;
    fwd_req.opaq = {grant, sel_req.opaq};
    fwd_req.addr = sel_req.addr;
    fwd_req.data = sel_req.data;
    mem_req_msg  = fwd_req;
    mem_req_val  = rst && !full && (grant ? req1_val : req0_val);
    req0_rdy     = rst && mem_req_rdy && !full && !grant;
    req1_rdy     = rst && mem_req_rdy && !full && grant;

    mem_resp      = mem_resp_msg;
    resp_id       = mem_resp.opaq[ID_BIT];
    ret_resp.op   = mem_resp.op;
    ret_resp.opaq = mem_resp.opaq[p_opaq_bits-1:0];
    ret_resp.data = mem_resp.data;
    resp0_msg     = ret_resp;
    resp1_msg     = ret_resp;
    resp0_val     = rst && mem_resp_val && !resp_id;
    resp1_val     = rst && mem_resp_val && resp_id;
    mem_resp_rdy  = rst && (resp_id ? resp1_rdy : resp0_rdy);

    req_fire  = mem_req_val && mem_req_rdy;
    resp_fire = mem_resp_val && mem_resp_rdy;
    cnt_d     = cnt_q;
    if (req_fire && !resp_fire)
      cnt_d = cnt_q + 1'b1;
    else if (!req_fire && resp_fire && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      assert (!(resp_fire && cnt_q == '0));
    end
  end

  function automatic string trace(input int level);
    string s;
    s = $sformatf("g%0d %s o%0d %s%s%s%s", grant, lock ? "L" : "-", cnt_q,
                  (req0_val && req0_rdy) ? "q0" : "..", (req1_val && req1_rdy) ? "q1" : "..",
                  (resp0_val && resp0_rdy) ? "r0" : "..", (resp1_val && resp1_rdy) ? "r1" : "..");
    if (level > 1)
      s = {s, (fwd_req.op == MEM_OP_WRITE) ? " wr" : ((fwd_req.op == MEM_OP_READ) ? " rd" : " ??")};
    return s;
  endfunction

endmodule

// File: tb/tb_mem_intf_arbiter.sv
// tb/tb_mem_intf_arbiter.sv - directed vector bench for mem_intf_arbiter
module tb_mem_intf_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_val, req1_val, resp0_rdy, resp1_rdy, mem_req_rdy, mem_resp_val;
  logic [72:0] req0_msg, req1_msg;
  logic [41:0] mem_resp_msg;

  logic        a_r0rdy, a_r1rdy, a_rv0, a_rv1, a_mqv, a_mrsp_rdy;
  logic [40:0] a_resp0_msg, a_resp1_msg;
  logic [73:0] a_mreq_msg;
  logic        b_r0rdy, b_r1rdy, b_rv0, b_rv1, b_mqv, b_mrsp_rdy;
  logic [40:0] b_resp0_msg, b_resp1_msg;
  logic [73:0] b_mreq_msg;

  int n_cmp = 0;
  int n_bad = 0;

  always #10 clk = ~clk;

  mem_intf_arbiter u_a (
    .clk(clk), .rst(rst),
    .req0_val(req0_val), .req0_rdy(a_r0rdy), .req0_msg(req0_msg),
    .req1_val(req1_val), .req1_rdy(a_r1rdy), .req1_msg(req1_msg),
    .resp0_val(a_rv0), .resp0_rdy(resp0_rdy), .resp0_msg(a_resp0_msg),
    .resp1_val(a_rv1), .resp1_rdy(resp1_rdy), .resp1_msg(a_resp1_msg),
    .mem_req_val(a_mqv), .mem_req_rdy(mem_req_rdy), .mem_req_msg(a_mreq_msg),
    .mem_resp_val(mem_resp_val), .mem_resp_rdy(a_mrsp_rdy), .mem_resp_msg(mem_resp_msg)
  );

  mem_intf_arbiter #(.p_opaq_bits(8), .p_max_outstanding(2)) u_b (
    .clk(clk), .rst(rst),
    .req0_val(req0_val), .req0_rdy(b_r0rdy), .req0_msg(req0_msg),
    .req1_val(req1_val), .req1_rdy(b_r1rdy), .req1_msg(req1_msg),
    .resp0_val(b_rv0), .resp0_rdy(resp0_rdy), .resp0_msg(b_resp0_msg),
    .resp1_val(b_rv1), .resp1_rdy(resp1_rdy), .resp1_msg(b_resp1_msg),
    .mem_req_val(b_mqv), .mem_req_rdy(mem_req_rdy), .mem_req_msg(b_mreq_msg),
    .mem_resp_val(mem_resp_val), .mem_resp_rdy(b_mrsp_rdy), .mem_resp_msg(mem_resp_msg)
  );

  typedef struct {
    logic r0v, r1v, mrr, mrsv, rr0, rr1, rid;
    logic e_mqv, e_r0rdy, e_r1rdy, e_grant, e_rv0, e_rv1, e_mrsp_rdy;
  } vec_t;

  function automatic logic [72:0] mk_req(input logic op, input logic [7:0] opq, input logic [31:0] ad, input logic [31:0] d);
    return {op, opq, ad, d};
  endfunction
  function automatic logic [73:0] mk_mreq(input logic op, input logic id, input logic [7:0] opq, input logic [31:0] ad, input logic [31:0] d);
    return {op, id, opq, ad, d};
  endfunction
  function automatic logic [41:0] mk_mresp(input logic op, input logic id, input logic [7:0] opq, input logic [31:0] d);
    return {op, id, opq, d};
  endfunction
  function automatic logic [40:0] mk_resp(input logic op, input logic [7:0] opq, input logic [31:0] d);
    return {op, opq, d};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0_val = 1'b0; req1_val = 1'b0; mem_req_rdy = 1'b0;
    mem_resp_val = 1'b0; resp0_rdy = 1'b0; resp1_rdy = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{0,0,1,0,0,0,0,  0,1,0,0,0,0,0};
    vecs[1] = '{0,1,1,0,0,0,0,  1,0,1,1,0,0,0};
    vecs[2] = '{1,0,0,0,0,0,0,  1,0,0,0,0,0,0};
    vecs[3] = '{1,1,1,1,0,1,1,  1,1,0,0,0,1,1};
    vecs[4] = '{0,1,0,1,0,1,0,  1,0,0,1,1,0,0};
    vecs[5] = '{0,0,0,0,1,0,0,  0,0,0,0,0,0,1};

    // Reset asserted with every input active: all handshakes must stay low.
    rst = 1'b0;
    req0_val = 1'b1; req1_val = 1'b1; mem_req_rdy = 1'b1;
    mem_resp_val = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
    req0_msg = mk_req(0, 8'h01, 32'h100, 32'h0);
    req1_msg = mk_req(1, 8'h02, 32'h104, 32'h77);
    mem_resp_msg = mk_mresp(0, 0, 8'h00, 32'h0);
    #2;
    chk("rst_mqv", a_mqv, 0);
    chk("rst_rdy", {a_r0rdy, a_r1rdy}, 0);
    chk("rst_rv", {a_rv0, a_rv1}, 0);
    chk("rst_mrsp_rdy", a_mrsp_rdy, 0);
    chk("rst_cnt", u_a.cnt_q, 0);
    tick();
    idle();
    rst = 1'b1;

    // Combinational vectors, all applied between two edges so nothing fires.
    tick();
    for (int i = 0; i < 6; i++) begin
      req0_val = vecs[i].r0v; req1_val = vecs[i].r1v; mem_req_rdy = vecs[i].mrr;
      mem_resp_val = vecs[i].mrsv; resp0_rdy = vecs[i].rr0; resp1_rdy = vecs[i].rr1;
      mem_resp_msg = mk_mresp(0, vecs[i].rid, 8'h3C, 32'h0BAD_F00D);
      #1;
      chk($sformatf("v%0d_mqv", i), a_mqv, vecs[i].e_mqv);
      chk($sformatf("v%0d_r0rdy", i), a_r0rdy, vecs[i].e_r0rdy);
      chk($sformatf("v%0d_r1rdy", i), a_r1rdy, vecs[i].e_r1rdy);
      chk($sformatf("v%0d_grant", i), a_mreq_msg[72], vecs[i].e_grant);
      chk($sformatf("v%0d_rv0", i), a_rv0, vecs[i].e_rv0);
      chk($sformatf("v%0d_rv1", i), a_rv1, vecs[i].e_rv1);
      chk($sformatf("v%0d_mrsp_rdy", i), a_mrsp_rdy, vecs[i].e_mrsp_rdy);
    end
    idle();

    // Single read, then its response routed back to requester 0.
    do_reset();
    req0_msg = mk_req(0, 8'h05, 32'h200, 32'h0);
    req0_val = 1'b1; mem_req_rdy = 1'b1;
    #1;
    chk("rd_mqv", a_mqv, 1);
    chk("rd_mreq_msg", a_mreq_msg, mk_mreq(0, 0, 8'h05, 32'h200, 32'h0));
    chk("rd_r0rdy", a_r0rdy, 1);
    tick();
    req0_val = 1'b0;
    #1;
    chk("rd_cnt1", u_a.cnt_q, 1);
    mem_resp_val = 1'b1; resp0_rdy = 1'b1;
    mem_resp_msg = mk_mresp(0, 0, 8'h05, 32'hDEADBEEF);
    #1;
    chk("rd_rv0", a_rv0, 1);
    chk("rd_rv1", a_rv1, 0);
    chk("rd_resp0_msg", a_resp0_msg, mk_resp(0, 8'h05, 32'hDEADBEEF));
    chk("rd_mrsp_rdy", a_mrsp_rdy, 1);
    tick();
    mem_resp_val = 1'b0;
    #1;
    chk("rd_cnt0", u_a.cnt_q, 0);

    // Fairness: both requesting, memory always ready, responses keep the count low.
    do_reset();
    req0_val = 1'b1; req1_val = 1'b1; mem_req_rdy = 1'b1; resp0_rdy = 1'b1;
    mem_resp_msg = mk_mresp(0, 0, 8'h09, 32'h0);
    for (int i = 0; i < 6; i++) begin
      mem_resp_val = (i > 0);
      #1;
      chk($sformatf("fair_grant%0d", i), a_mreq_msg[72], i % 2);
      tick();
    end
    idle();
    #1;
    chk("fair_cnt", u_a.cnt_q, 1);

    // Stall lock with requester 0 holding the port.
    do_reset();
    req0_msg = mk_req(1, 8'h11, 32'h300, 32'hA5A5);
    req1_msg = mk_req(0, 8'h22, 32'h400, 32'h0);
    req0_val = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) req1_val = 1'b1;
      #1;
      chk($sformatf("stall%0d_mqv", c), a_mqv, 1);
      chk($sformatf("stall%0d_msg", c), a_mreq_msg, mk_mreq(1, 0, 8'h11, 32'h300, 32'hA5A5));
      chk($sformatf("stall%0d_r1rdy", c), a_r1rdy, 0);
      tick();
    end
    mem_req_rdy = 1'b1;
    #1;
    chk("stall_r0rdy", a_r0rdy, 1);
    tick();
    req0_val = 1'b0;
    #1;
    chk("stall_next_grant", a_mreq_msg[72], 1);
    chk("stall_next_msg", a_mreq_msg, mk_mreq(0, 1, 8'h22, 32'h400, 32'h0));
    tick();
    // prio now favours 0; a stalled requester 1 must still keep the grant.
    mem_req_rdy = 1'b0;
    tick();
    req0_val = 1'b1;
    #1;
    chk("lock1_grant", a_mreq_msg[72], 1);
    chk("lock1_r0rdy", a_r0rdy, 0);
    tick();
    mem_req_rdy = 1'b1;
    #1;
    chk("lock1_r1rdy", a_r1rdy, 1);
    tick();
    req1_val = 1'b0; req0_val = 1'b0;
    #1;
    chk("lock1_after_grant", a_mreq_msg[72], 0);
    idle();

    // Credit limit on the instance capped at two outstanding.
    do_reset();
    req1_msg = mk_req(0, 8'h33, 32'h500, 32'h0);
    req1_val = 1'b1; mem_req_rdy = 1'b1;
    #1;
    chk("cred_r1rdy_first", b_r1rdy, 1);
    tick();
    #1;
    chk("cred_cnt1", u_b.cnt_q, 1);
    tick();
    #1;
    chk("cred_cnt2", u_b.cnt_q, 2);
    chk("cred_full_mqv", b_mqv, 0);
    chk("cred_full_r1rdy", b_r1rdy, 0);
    mem_resp_val = 1'b1; resp1_rdy = 1'b1;
    mem_resp_msg = mk_mresp(0, 1, 8'h33, 32'h1234);
    #1;
    chk("cred_rv1", b_rv1, 1);
    chk("cred_mrsp_rdy", b_mrsp_rdy, 1);
    chk("cred_same_cycle_mqv", b_mqv, 0);
    tick();
    mem_resp_val = 1'b0;
    #1;
    chk("cred_cnt_after_resp", u_b.cnt_q, 1);
    chk("cred_reopen_mqv", b_mqv, 1);
    chk("cred_reopen_r1rdy", b_r1rdy, 1);
    tick();
    req1_val = 1'b0;
    #1;
    chk("cred_cnt_refill", u_b.cnt_q, 2);

    // Simultaneous request and response fire, then response backpressure.
    do_reset();
    req0_msg = mk_req(0, 8'h44, 32'h600, 32'h0);
    req0_val = 1'b1; mem_req_rdy = 1'b1;
    tick();
    tick();
    #1;
    chk("sim_cnt2", u_a.cnt_q, 2);
    mem_resp_val = 1'b1; resp1_rdy = 1'b1;
    mem_resp_msg = mk_mresp(0, 1, 8'h44, 32'h5555);
    #1;
    chk("sim_both_mqv", a_mqv, 1);
    chk("sim_both_mrsp_rdy", a_mrsp_rdy, 1);
    tick();
    req0_val = 1'b0; resp1_rdy = 1'b0;
    #1;
    chk("sim_cnt_hold", u_a.cnt_q, 2);
    chk("sim_bp_mrsp_rdy", a_mrsp_rdy, 0);
    chk("sim_bp_rv1", a_rv1, 1);
    tick();
    #1;
    chk("sim_bp_cnt", u_a.cnt_q, 2);
    resp1_rdy = 1'b1;
    #1;
    chk("sim_release_mrsp_rdy", a_mrsp_rdy, 1);
    tick();
    mem_resp_val = 1'b0;
    #1;
    chk("sim_cnt_dec", u_a.cnt_q, 1);

    // Reset dropped mid-lock with three outstanding.
    do_reset();
    req0_val = 1'b1; mem_req_rdy = 1'b1;
    tick(); tick(); tick();
    req0_val = 1'b0; req1_val = 1'b1; mem_req_rdy = 1'b0;
    tick();
    #1;
    chk("mr_cnt3", u_a.cnt_q, 3);
    chk("mr_lock", u_a.u_grant.lock, 1);
    rst = 1'b0;
    req0_val = 1'b1; mem_req_rdy = 1'b1; mem_resp_val = 1'b1;
    resp0_rdy = 1'b1; resp1_rdy = 1'b1;
    #1;
    chk("mr_mqv", a_mqv, 0);
    chk("mr_rdy", {a_r0rdy, a_r1rdy}, 0);
    chk("mr_rv", {a_rv0, a_rv1}, 0);
    chk("mr_mrsp_rdy", a_mrsp_rdy, 0);
    chk("mr_cnt0", u_a.cnt_q, 0);
    tick();
    mem_resp_val = 1'b0; mem_req_rdy = 1'b0;
    rst = 1'b1;
    #1;
    chk("mr_post_grant", a_mreq_msg[72], 0);
    chk("mr_post_mqv", a_mqv, 1);
    chk("mr_post_cnt", u_a.cnt_q, 0);
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
